// File: rtl/booth_mult_core.sv
// Radix-2 Booth signed multiplier: WIDTH steps from accepted start to a one-cycle done pulse.
// No backpressure: start is ignored while busy, and product holds until the next done.
module booth_mult_core #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mreg;
  logic [WIDTH-1:0] qreg;
  logic             q_1;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] qreg_next;
  logic             q_1_next;

  // acc carries one guard bit so subtracting the most negative multiplicand cannot overflow
  always_comb begin
    acc_sum = acc;
    case ({qreg[0], q_1})
      2'b01:   acc_sum = acc + mreg;
      2'b10:   acc_sum = acc - mreg;
      default: acc_sum = acc;
    endcase
    acc_next  = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    qreg_next = {acc_sum[0], qreg[WIDTH-1:1]};
    q_1_next  = qreg[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mreg    <= '0;
      qreg    <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mreg  <= {multiplicand[WIDTH-1], multiplicand};
            acc   <= '0;
            qreg  <= multiplier;
            q_1   <= 1'b0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc  <= acc_next;
          qreg <= qreg_next;
          q_1  <= q_1_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            product <= {acc_next[WIDTH-1:0], qreg_next};
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_core.sv
// Bench for booth_mult_core: directed cases plus a randomized sweep against signed integer multiplication.
module tb_booth_mult_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  booth_mult_core #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .multiplicand(multiplicand), .multiplier(multiplier),
    .start(start), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation (accepting edge E0) and returns after E(17), back in IDLE.
  task automatic do_mult(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output int lat, output int busy_cyc);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    step();
    start        = 1'b0;
    multiplicand = 16'($urandom);
    multiplier   = 16'($urandom);
    busy_cyc = (busy === 1'b1) ? 1 : 0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      step();
      lat++;
      if (busy === 1'b1) busy_cyc++;
    end
    p = product;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    step();
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=00000000", product); end
  endtask

  task automatic test_basic();
    logic [31:0] p;
    int lat, bc, d0;
    d0 = done_cnt;
    do_mult(16'd3, 16'd5, p, lat, bc);
    checks++; if (p !== 32'h0000000F) begin errors++; $display("FAIL basic_product got=%h exp=0000000f", p); end
    checks++; if (lat != 16) begin errors++; $display("FAIL basic_latency got=%0d exp=16", lat); end
    checks++; if (bc != 17) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=17", bc); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle_after got=busy%b/done%b exp=0/0", busy, done); end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_signed();
    logic [15:0] av [4] = '{16'hFFF9, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [15:0] bv [4] = '{16'h0006, 16'hFFFF, 16'h8000, 16'h8000};
    logic [31:0] ev [4] = '{32'hFFFFFFD6, 32'h00000001, 32'h40000000, 32'hC0008000};
    logic [31:0] p;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      do_mult(av[i], bv[i], p, lat, bc);
      checks++;
      if (p !== ev[i]) begin
        errors++;
        $display("FAIL signed_%0d %h*%h got=%h exp=%h", i, av[i], bv[i], p, ev[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] p;
    int lat, bc;
    multiplicand = 16'd100;
    multiplier   = 16'hFFFD;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    multiplicand = 16'h1234;
    multiplier   = 16'h0002;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 6;
    while (done !== 1'b1 && lat < 40) begin step(); lat++; end
    checks++; if (lat != 16) begin errors++; $display("FAIL ignore_calc_latency got=%0d exp=16", lat); end
    checks++; if (product !== 32'hFFFFFED4) begin errors++; $display("FAIL ignore_calc_product got=%h exp=fffffed4", product); end
    // start presented while in DONE (sampled at E17) must be dropped
    multiplicand = 16'h0009;
    multiplier   = 16'h0009;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_done_busy got=%b exp=0", busy); end
    checks++; if (product !== 32'hFFFFFED4) begin errors++; $display("FAIL ignore_done_product got=%h exp=fffffed4", product); end
    do_mult(16'h0011, 16'h0003, p, lat, bc);
    checks++; if (p !== 32'h00000033) begin errors++; $display("FAIL ignore_next_product got=%h exp=00000033", p); end
  endtask

  task automatic test_back_to_back();
    int done_at [$];
    int cyc;
    multiplicand = 16'd5;
    multiplier   = 16'd7;
    start = 1'b1;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      cyc++;
      if (done === 1'b1) done_at.push_back(cyc);
    end
    start = 1'b0;
    repeat (25) step();
    checks++; if (done_at.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", done_at.size()); end
    if (done_at.size() >= 3) begin
      checks++; if (done_at[0] != 17) begin errors++; $display("FAIL b2b_first got=%0d exp=17", done_at[0]); end
      checks++; if (done_at[1] - done_at[0] != 18 || done_at[2] - done_at[1] != 18) begin
        errors++; $display("FAIL b2b_period got=%0d,%0d exp=18", done_at[1] - done_at[0], done_at[2] - done_at[1]);
      end
    end
    checks++; if (product !== ref_mul(16'd5, 16'd7)) begin errors++; $display("FAIL b2b_product got=%h exp=%h", product, ref_mul(16'd5, 16'd7)); end
  endtask

  task automatic test_abort();
    logic [31:0] p;
    int lat, bc, d0;
    multiplicand = 16'd7;
    multiplier   = 16'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    d0 = done_cnt;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (product !== 32'h0) begin errors++; $display("FAIL abort_product got=%h exp=00000000", product); end
    repeat (25) step();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
    do_mult(16'd2, 16'd2, p, lat, bc);
    checks++; if (p !== 32'h00000004) begin errors++; $display("FAIL abort_after_product got=%h exp=00000004", p); end
  endtask

  task automatic test_random();
    logic [15:0] corner [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0002};
    logic [15:0] a, b;
    logic [31:0] p, e;
    int lat, bc, d0;
    for (int i = 0; i < 1100; i++) begin
      if (i < 36) begin
        a = corner[i / 6];
        b = corner[i % 6];
      end else begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      e = ref_mul(a, b);
      d0 = done_cnt;
      do_mult(a, b, p, lat, bc);
      checks++; if (p !== e) begin errors++; $display("FAIL rand_product %h*%h got=%h exp=%h", a, b, p, e); end
      checks++; if (lat != 16) begin errors++; $display("FAIL rand_latency %h*%h got=%0d exp=16", a, b, lat); end
      checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL rand_done_pulses %h*%h got=%0d exp=1", a, b, done_cnt - d0); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
